// File: rtl/timer_pkg.sv
// Shared definitions for the timer scheduler: channel count, channel
// state encoding, default prescaler value and the round-robin helper.
package timer_pkg;

    localparam int          NUM_CH           = 4;
    localparam int unsigned DEFAULT_PRESCALE = 2000000;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chanState_e;

    // Picks the first requesting channel starting at ptr and wrapping
    // around. The scan runs backwards so the closest request to ptr is
    // the last one written. With no request the pointer itself is returned.
    function automatic logic [1:0] rrGrant(input logic [NUM_CH-1:0] req,
                                           input logic [1:0]        ptr);
        logic [1:0] idx;
        logic [1:0] grant;
        grant = ptr;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                grant = idx;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Shared prescaler: divides the system clock down to a one-cycle tick and
// keeps a free-running count of ticks since reset.
module tick_prescaler
    import timer_pkg::*;
#(
    parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
    input  logic        clock,
    input  logic        resetn,
    output logic        tick,
    output logic [31:0] tick_count
);

    localparam logic [31:0] LAST = 32'(PRESCALE - 1);

    logic [31:0] r_count;
    logic        r_tick;
    logic [31:0] r_tickCount;
    logic [31:0] w_countNext;

    // Next prescaler value, wrapping back to zero after the last count.
    always_comb begin
        w_countNext = (r_count == LAST) ? 32'd0 : r_count + 32'd1;
    end

    // Tick and tick count are registered so that both are visible in
    // exactly the cycle in which the counter holds its last value.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_count     <= 32'd0;
            r_tick      <= 1'b0;
            r_tickCount <= 32'd0;
        end else begin
            r_count <= w_countNext;
            r_tick  <= (w_countNext == LAST);
            if (w_countNext == LAST) begin
                r_tickCount <= r_tickCount + 32'd1;
            end
        end
    end

    assign tick       = r_tick;
    assign tick_count = r_tickCount;

endmodule

// File: rtl/timer_scheduler.sv
// Four-channel timer scheduler. Channels count down on the shared tick,
// raise pending events on expiry, and a round-robin arbiter presents one
// pending event at a time to the consumer.
module timer_scheduler
    import timer_pkg::*;
#(
    parameter int unsigned PRESCALE = DEFAULT_PRESCALE,
    parameter int          CW       = 16
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [1:0]        cfg_chan,
    input  logic              cfg_enable,
    input  logic              cfg_oneshot,
    input  logic [CW-1:0]     cfg_period,
    output logic              cfg_err,
    output logic              evt_valid,
    output logic [1:0]        evt_chan,
    input  logic              evt_ready,
    output logic              tick,
    output logic [31:0]       tick_count,
    output logic [NUM_CH-1:0] running,
    output logic [NUM_CH-1:0] overrun
);

    logic w_tick;

    chanState_e        r_state  [NUM_CH];
    logic [CW-1:0]     r_cnt    [NUM_CH];
    logic [CW-1:0]     r_period [NUM_CH];
    logic [NUM_CH-1:0] r_oneshot;
    logic [NUM_CH-1:0] r_pending;
    logic [NUM_CH-1:0] r_overrun;
    logic [1:0]        r_rrPtr;
    logic              r_evtValid;
    logic [1:0]        r_evtChan;
    logic              r_cfgReady;
    logic              r_cfgErr;

    chanState_e        w_stateNext  [NUM_CH];
    logic [CW-1:0]     w_cntNext    [NUM_CH];
    logic [CW-1:0]     w_periodNext [NUM_CH];
    logic [NUM_CH-1:0] w_oneshotNext;
    logic [NUM_CH-1:0] w_pendingNext;
    logic [NUM_CH-1:0] w_overrunNext;
    logic [NUM_CH-1:0] w_ack;
    logic              w_write;
    logic              w_ackValid;
    logic [1:0]        w_ptrNext;
    logic [1:0]        w_evtChanNext;
    logic              w_cfgErrNext;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clock      (clock),
        .resetn     (resetn),
        .tick       (w_tick),
        .tick_count (tick_count)
    );

    // Decode accepted configuration writes and event acknowledges.
    always_comb begin
        w_write    = cfg_valid & r_cfgReady;
        w_ackValid = r_evtValid & evt_ready;
        for (int i = 0; i < NUM_CH; i++) begin
            w_ack[i] = w_ackValid && (r_evtChan == 2'(i));
        end
        w_cfgErrNext = w_write & cfg_enable & (cfg_period == '0);
    end

    // Per-channel next state. A write to a channel takes priority over a
    // tick in the same cycle, so the tick is simply not seen by that channel.
    // An acknowledge clears pending unless a new expiry re-arms it.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_stateNext[i]   = r_state[i];
            w_cntNext[i]     = r_cnt[i];
            w_periodNext[i]  = r_period[i];
            w_oneshotNext[i] = r_oneshot[i];
            w_overrunNext[i] = r_overrun[i];
            w_pendingNext[i] = r_pending[i] & ~w_ack[i];

            if (w_write && (cfg_chan == 2'(i))) begin
                if (cfg_enable && (cfg_period != '0)) begin
                    w_stateNext[i]   = RUN;
                    w_cntNext[i]     = cfg_period;
                    w_periodNext[i]  = cfg_period;
                    w_oneshotNext[i] = cfg_oneshot;
                    w_overrunNext[i] = 1'b0;
                end else if (cfg_enable) begin
                    w_stateNext[i]   = IDLE;
                    w_cntNext[i]     = '0;
                    w_pendingNext[i] = 1'b0;
                end else begin
                    w_stateNext[i]   = IDLE;
                    w_cntNext[i]     = '0;
                    w_pendingNext[i] = 1'b0;
                    w_overrunNext[i] = 1'b0;
                end
            end else if (w_tick && (r_state[i] == RUN)) begin
                if (r_cnt[i] > CW'(1)) begin
                    w_cntNext[i] = r_cnt[i] - CW'(1);
                end else if (r_cnt[i] == CW'(1)) begin
                    if (r_pending[i] && !w_ack[i]) begin
                        w_overrunNext[i] = 1'b1;
                    end
                    w_pendingNext[i] = 1'b1;
                    if (r_oneshot[i]) begin
                        w_stateNext[i] = IDLE;
                        w_cntNext[i]   = '0;
                    end else begin
                        w_cntNext[i] = r_period[i];
                    end
                end
            end
        end
    end

    // Round-robin arbitration. The presented channel is frozen while the
    // consumer stalls, unless that channel's event was withdrawn by a write.
    always_comb begin
        w_ptrNext = w_ackValid ? (r_evtChan + 2'd1) : r_rrPtr;
        if (r_evtValid && !evt_ready && w_pendingNext[r_evtChan]) begin
            w_evtChanNext = r_evtChan;
        end else begin
            w_evtChanNext = rrGrant(w_pendingNext, w_ptrNext);
        end
    end

    // Register all channel state, arbiter state and the handshake outputs.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i]  <= IDLE;
                r_cnt[i]    <= '0;
                r_period[i] <= '0;
            end
            r_oneshot  <= '0;
            r_pending  <= '0;
            r_overrun  <= '0;
            r_rrPtr    <= 2'd0;
            r_evtValid <= 1'b0;
            r_evtChan  <= 2'd0;
            r_cfgReady <= 1'b0;
            r_cfgErr   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i]  <= w_stateNext[i];
                r_cnt[i]    <= w_cntNext[i];
                r_period[i] <= w_periodNext[i];
            end
            r_oneshot  <= w_oneshotNext;
            r_pending  <= w_pendingNext;
            r_overrun  <= w_overrunNext;
            r_rrPtr    <= w_ptrNext;
            r_evtValid <= |w_pendingNext;
            r_evtChan  <= w_evtChanNext;
            r_cfgReady <= ~w_write;
            r_cfgErr   <= w_cfgErrNext;
        end
    end

    // Expose the per-channel RUN state as a flat vector.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            running[i] = (r_state[i] == RUN);
        end
    end

    assign tick      = w_tick;
    assign cfg_ready = r_cfgReady;
    assign cfg_err   = r_cfgErr;
    assign evt_valid = r_evtValid;
    assign evt_chan  = r_evtChan;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_timer_scheduler.sv
// Self-checking bench for timer_scheduler with a short prescaler. Expected
// events are queued as each scenario is set up and compared against every
// handshake the scheduler produces.
module tb_timer_scheduler;

    localparam int PRESCALE = 4;
    localparam int CW       = 16;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [1:0]    cfg_chan = 2'd0;
    logic          cfg_enable = 1'b0;
    logic          cfg_oneshot = 1'b0;
    logic [CW-1:0] cfg_period = '0;
    logic          cfg_err;
    logic          evt_valid;
    logic [1:0]    evt_chan;
    logic          evt_ready = 1'b0;
    logic          tick;
    logic [31:0]   tick_count;
    logic [3:0]    running;
    logic [3:0]    overrun;

    typedef struct {
        int chan;
        int tc;
    } expEvt_t;

    expEvt_t expQ[$];
    int      checkCount = 0;
    int      errorCount = 0;
    int      cyc = 0;
    logic    tickMonOn = 1'b0;

    timer_scheduler #(
        .PRESCALE (PRESCALE),
        .CW       (CW)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_chan    (cfg_chan),
        .cfg_enable  (cfg_enable),
        .cfg_oneshot (cfg_oneshot),
        .cfg_period  (cfg_period),
        .cfg_err     (cfg_err),
        .evt_valid   (evt_valid),
        .evt_chan    (evt_chan),
        .evt_ready   (evt_ready),
        .tick        (tick),
        .tick_count  (tick_count),
        .running     (running),
        .overrun     (overrun)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    // Cycle index since reset release; cycle 0 is the first cycle with
    // resetn high, so ticks are expected whenever cyc mod PRESCALE is last.
    always @(posedge clock) begin
        cyc <= resetn ? cyc + 1 : 0;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)",
                     tag, observed, expected, cyc);
        end
    endtask

    // Tick pattern is checked in every cycle once the first reset is done.
    always @(negedge clock) begin
        if (tickMonOn) begin
            checkOutput("tick", 32'(tick), 32'((cyc % PRESCALE) == (PRESCALE - 1)));
        end
    end

    // Every handshake must match the oldest queued expectation.
    always @(negedge clock) begin : evtMon
        expEvt_t e;
        if (resetn && evt_valid && evt_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedEvtChan", 32'(evt_chan), 32'hFFFF_FFFF);
            end else begin
                e = expQ.pop_front();
                checkOutput("evtChan", 32'(evt_chan), 32'(e.chan));
                checkOutput("evtTickCount", tick_count, 32'(e.tc));
            end
        end
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic gotoCycle(input int target);
        int guard;
        guard = 0;
        while (cyc < target && guard < 1000) begin
            nextCycle();
            guard++;
        end
        if (guard >= 1000) begin
            checkOutput("gotoCycleTimeout", 32'(cyc), 32'(target));
        end
    endtask

    task automatic checkResetValues();
        checkOutput("rstTick", 32'(tick), 32'd0);
        checkOutput("rstTickCount", tick_count, 32'd0);
        checkOutput("rstEvtValid", 32'(evt_valid), 32'd0);
        checkOutput("rstEvtChan", 32'(evt_chan), 32'd0);
        checkOutput("rstCfgErr", 32'(cfg_err), 32'd0);
        checkOutput("rstCfgReady", 32'(cfg_ready), 32'd0);
        checkOutput("rstRunning", 32'(running), 32'd0);
        checkOutput("rstOverrun", 32'(overrun), 32'd0);
    endtask

    // Holds reset for three edges and releases it; returns in cycle 0.
    task automatic doReset(input bit checkVals);
        resetn    = 1'b0;
        cfg_valid = 1'b0;
        evt_ready = 1'b0;
        repeat (3) nextCycle();
        if (checkVals) begin
            checkResetValues();
        end
        resetn    = 1'b1;
        tickMonOn = 1'b1;
    endtask

    // Issues one configuration write, accepted at the end of the current cycle.
    task automatic applyStimulus(input logic [1:0] ch, input logic en,
                                 input logic os, input logic [CW-1:0] per);
        int guard;
        guard = 0;
        while (!cfg_ready && guard < 20) begin
            nextCycle();
            guard++;
        end
        if (!cfg_ready) begin
            checkOutput("cfgReadyTimeout", 32'(cfg_ready), 32'd1);
        end
        cfg_valid   = 1'b1;
        cfg_chan    = ch;
        cfg_enable  = en;
        cfg_oneshot = os;
        cfg_period  = per;
        nextCycle();
        cfg_valid = 1'b0;
    endtask

    initial begin
        // Reset values and idle tick behaviour.
        doReset(1'b1);
        checkOutput("cfgReadyCycle0", 32'(cfg_ready), 32'd0);
        nextCycle();
        checkOutput("cfgReadyCycle1", 32'(cfg_ready), 32'd1);
        gotoCycle(12);
        checkOutput("idleTickCount", tick_count, 32'd3);
        checkOutput("idleEvtValid", 32'(evt_valid), 32'd0);

        // Periodic channel 0, period 2: event after every second tick.
        doReset(1'b0);
        evt_ready = 1'b1;
        expQ.push_back('{chan: 0, tc: 2});
        expQ.push_back('{chan: 0, tc: 4});
        expQ.push_back('{chan: 0, tc: 6});
        gotoCycle(1);
        applyStimulus(2'd0, 1'b1, 1'b0, 16'd2);
        gotoCycle(4);
        checkOutput("perNoEvtFirstTick", 32'(evt_valid), 32'd0);
        gotoCycle(9);
        checkOutput("perEvtOneCycle", 32'(evt_valid), 32'd0);
        gotoCycle(10);
        checkOutput("perRunning", 32'(running), 32'h1);
        gotoCycle(28);
        applyStimulus(2'd0, 1'b0, 1'b0, 16'd0);
        checkOutput("perStopped", 32'(running), 32'h0);
        gotoCycle(40);
        checkOutput("perQueueEmpty", 32'(expQ.size()), 32'd0);

        // One-shot channel 1, period 1: a single event then idle.
        doReset(1'b0);
        evt_ready = 1'b1;
        expQ.push_back('{chan: 1, tc: 1});
        gotoCycle(1);
        applyStimulus(2'd1, 1'b1, 1'b1, 16'd1);
        checkOutput("osRunning", 32'(running), 32'h2);
        gotoCycle(4);
        checkOutput("osStopped", 32'(running), 32'h0);
        gotoCycle(20);
        checkOutput("osQueueEmpty", 32'(expQ.size()), 32'd0);

        // Channels 0 and 2, period 1, consumer stalled for three ticks.
        doReset(1'b0);
        expQ.push_back('{chan: 0, tc: 3});
        expQ.push_back('{chan: 2, tc: 3});
        expQ.push_back('{chan: 0, tc: 4});
        expQ.push_back('{chan: 2, tc: 4});
        expQ.push_back('{chan: 0, tc: 5});
        expQ.push_back('{chan: 2, tc: 5});
        gotoCycle(1);
        applyStimulus(2'd0, 1'b1, 1'b0, 16'd1);
        gotoCycle(4);
        applyStimulus(2'd2, 1'b1, 1'b0, 16'd1);
        gotoCycle(9);
        checkOutput("ovrHoldChan", 32'(evt_chan), 32'd0);
        gotoCycle(12);
        checkOutput("ovrFlags", 32'(overrun), 32'h5);
        checkOutput("ovrEvtValid", 32'(evt_valid), 32'd1);
        checkOutput("ovrRunning", 32'(running), 32'h5);
        evt_ready = 1'b1;
        gotoCycle(22);
        evt_ready = 1'b0;
        checkOutput("ovrSticky", 32'(overrun), 32'h5);
        checkOutput("ovrQueueEmpty", 32'(expQ.size()), 32'd0);

        // Zero period rejection, then a rewrite coinciding with a tick.
        doReset(1'b0);
        evt_ready = 1'b1;
        expQ.push_back('{chan: 1, tc: 5});
        gotoCycle(1);
        checkOutput("errIdleLow", 32'(cfg_err), 32'd0);
        applyStimulus(2'd3, 1'b1, 1'b0, 16'd0);
        checkOutput("errPulse", 32'(cfg_err), 32'd1);
        checkOutput("errRunning", 32'(running), 32'h0);
        checkOutput("errReadyGap", 32'(cfg_ready), 32'd0);
        nextCycle();
        checkOutput("errPulseEnd", 32'(cfg_err), 32'd0);
        gotoCycle(5);
        applyStimulus(2'd1, 1'b1, 1'b0, 16'd2);
        checkOutput("wrReadyGap", 32'(cfg_ready), 32'd0);
        nextCycle();
        checkOutput("wrReadyBack", 32'(cfg_ready), 32'd1);
        gotoCycle(11);
        applyStimulus(2'd1, 1'b1, 1'b0, 16'd2);
        gotoCycle(22);
        checkOutput("wrTickQueueEmpty", 32'(expQ.size()), 32'd0);

        // Reset while an event is pending: everything is discarded.
        doReset(1'b0);
        gotoCycle(1);
        applyStimulus(2'd0, 1'b1, 1'b0, 16'd1);
        gotoCycle(5);
        checkOutput("midPending", 32'(evt_valid), 32'd1);
        gotoCycle(6);
        resetn = 1'b0;
        nextCycle();
        checkResetValues();
        nextCycle();
        resetn    = 1'b1;
        evt_ready = 1'b1;
        nextCycle();
        checkOutput("relCfgReady", 32'(cfg_ready), 32'd1);
        gotoCycle(12);
        checkOutput("relEvtValid", 32'(evt_valid), 32'd0);
        checkOutput("relRunning", 32'(running), 32'h0);
        checkOutput("relQueueEmpty", 32'(expQ.size()), 32'd0);

        tickMonOn = 1'b0;
        nextCycle();
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/timer_scheduler.md
TIMER_SCHEDULER -- requirements
Module: timer_scheduler

Interface
REQ-001 Parameter PRESCALE, default 2000000, clock cycles per shared tick (legal range 2..2^32-1).
REQ-002 Parameter CW, default 16, channel period width.
REQ-003 clock  input  1  single system clock; all state updates on posedge.
REQ-004 resetn  input  1  synchronous, active-low reset, sampled on posedge clock.
REQ-005 cfg_valid  input  1  configuration write request.
REQ-006 cfg_ready  output  1  configuration write accepted when both cfg_valid and cfg_ready are high.
REQ-007 cfg_chan  input  2  target channel 0..3.
REQ-008 cfg_enable  input  1  1 = start or restart the channel, 0 = stop it.
REQ-009 cfg_oneshot  input  1  1 = expire once then stop, 0 = periodic.
REQ-010 cfg_period  input  CW  period in ticks.
REQ-011 cfg_err  output  1  one-cycle pulse when a write is rejected.
REQ-012 evt_valid  output  1  an expiry event is pending.
REQ-013 evt_chan  output  2  channel of the presented event.
REQ-014 evt_ready  input  1  consumer accepts the event.
REQ-015 tick  output  1  one-cycle shared prescaler pulse.
REQ-016 tick_count  output  32  number of ticks since reset, wraps modulo 2^32.
REQ-017 running  output  4  per-channel RUN state.
REQ-018 overrun  output  4  per-channel sticky overrun flags.

Function
REQ-019 Prescaler: counts 0..PRESCALE-1 and wraps to 0; tick=1 exactly in the cycle the count equals PRESCALE-1; tick_count increments in that same cycle.
REQ-020 cfg_ready shall be 1 in every cycle except the cycle immediately after an accepted write (two-cycle minimum write spacing).
REQ-021 Each channel has two states, IDLE and RUN, plus a down-counter cnt[CW-1:0] and a pending bit.
REQ-022 Accepted write with cfg_enable=1 and cfg_period!=0: load cnt=cfg_period, latch oneshot and period, enter RUN, clear that channel's overrun flag; the pending bit is unchanged.
REQ-023 Accepted write with cfg_enable=1 and cfg_period=0: pulse cfg_err in the next cycle, force the channel to IDLE, and clear its pending bit.
REQ-024 Accepted write with cfg_enable=0: enter IDLE, set cnt=0, and clear the pending bit and overrun flag.
REQ-025 On a tick in RUN with cnt>1: decrement cnt.
REQ-026 On a tick in RUN with cnt==1: set pending; if oneshot, enter IDLE with cnt=0; otherwise reload cnt=period.
REQ-027 Expiry while pending is already 1 and that bit is not being acknowledged in the same cycle: set overrun for that channel; pending stays 1.
REQ-028 A write and a tick in the same cycle on the same channel: the write wins, and the tick is ignored for that channel only.
REQ-029 evt_valid shall be 1 while any pending bit is set; evt_chan comes from a round-robin grant starting at the channel after the last acknowledged one (channel 0 is first after reset).
REQ-030 While evt_valid=1 and evt_ready=0, evt_chan shall be held stable.
REQ-031 On handshake (evt_valid and evt_ready), clear pending[evt_chan] and advance the round-robin pointer.
REQ-032 An expiry and an acknowledge of the same channel in the same cycle: pending stays 1 and overrun is not set.
REQ-033 Latency: an expiry on tick cycle N makes evt_valid=1 at cycle N+1.
REQ-034 evt_valid, evt_chan, tick, and cfg_err shall be registered outputs.

Reset
REQ-035 While resetn=0 at posedge: prescaler=0, tick=0, tick_count=0, all channels IDLE, cnt=0, pending=0, overrun=0, round-robin pointer=0, evt_valid=0, evt_chan=0, cfg_err=0, cfg_ready=0.
REQ-036 Reset asserted mid-countdown or mid-handshake shall discard all state; cfg_ready=1 in the first cycle after resetn returns to 1.

Structure
REQ-037 A shared package timer_pkg shall hold NUM_CH=4, the channel-state enum (IDLE, RUN), and the default PRESCALE.
REQ-038 The prescaler (REQ-019) shall be the single sub-module tick_prescaler, with outputs tick and tick_count.
REQ-039 Channel logic and the round-robin arbiter shall live in timer_scheduler; no other sub-modules.

Verification (PRESCALE=4)
REQ-040 Reset, then idle for 12 cycles -> tick pulses at cycles 3, 7, 11; tick_count=3; evt_valid=0.
REQ-041 Write ch0 periodic period=2, evt_ready=1 -> evt_valid pulses one cycle after every second tick, with evt_chan=0.
REQ-042 Write ch1 oneshot period=1 -> exactly one event with evt_chan=1, then running[1]=0.
REQ-043 Ch0 and ch2 periodic period=1, evt_ready=0 for 3 ticks, then 1 -> overrun[0]=overrun[2]=1; events are granted 0, 2, 0, 2 ...
REQ-044 Write period=0 -> cfg_err pulse, running unchanged at 0; a write coincident with a tick on the same channel -> cnt equals the new period.
REQ-045 Assert resetn=0 mid-countdown with pending events -> all outputs at reset values next cycle; no stale event after release.
